// File: rtl/link_table_pkg.sv
// Shared definitions for the link-table client: order type codes, FSM state
// encodings, the fail payload and the result-decode helper.
package link_table_pkg;

   localparam logic [1:0] OP_APPE = 2'b00;
   localparam logic [1:0] OP_DELE = 2'b01;
   localparam logic [1:0] OP_CHAG = 2'b10;
   localparam logic [1:0] OP_READ = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_ISSUE = 2'b01;
   localparam logic [1:0] ST_WAIT  = 2'b10;
   localparam logic [1:0] ST_RESP  = 2'b11;

   // Payload returned to the host when an order fails without a manager result.
   localparam int unsigned LT_FAIL_DATA = 0;

   // READ always succeeds; write-type orders report failure as a zero result.
   function automatic logic result_ok(input logic [1:0] op, input logic data_nonzero);
      return (op == OP_READ) ? 1'b1 : data_nonzero;
   endfunction

endpackage

// File: rtl/link_table_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from read/write pointers that
// carry one extra wrap bit.
module link_table_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/link_table_client.sv
// Order initiator for the link-table manager: queues host commands, issues them
// one at a time and returns each result. Watchdog enabled by LT_CLIENT_TIMEOUT_EN.
module link_table_client
   import link_table_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int TABLE_WIDTH    = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_type,
   input  logic [TABLE_WIDTH-1:0] cmd_table,
   input  logic [ADDR_WIDTH-1:0]  cmd_node,
   input  logic [DATA_WIDTH-1:0]  cmd_data,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [1:0]             rsp_type,
   output logic [DATA_WIDTH-1:0]  rsp_data,
   output logic                   rsp_ok,
   output logic                   rsp_timeout,
   output logic                   order_valid,
   input  logic                   order_busy,
   output logic [1:0]             order_type,
   output logic [TABLE_WIDTH-1:0] order_table,
   output logic [ADDR_WIDTH-1:0]  order_node,
   output logic [DATA_WIDTH-1:0]  order_data,
   input  logic                   dout_valid,
   output logic                   dout_busy,
   input  logic [DATA_WIDTH-1:0]  dout_data,
   output logic                   idle
);

   localparam int FW = 2 + TABLE_WIDTH + ADDR_WIDTH + DATA_WIDTH;

   logic [FW-1:0]          head;
   logic                   fifo_full, fifo_empty, fifo_pop;
   logic [1:0]             head_type;
   logic [TABLE_WIDTH-1:0] head_table;
   logic [ADDR_WIDTH-1:0]  head_node;
   logic [DATA_WIDTH-1:0]  head_data;

   logic [1:0]             state_q, state_d;
   logic                   order_valid_q, order_valid_d;
   logic [1:0]             order_type_q, order_type_d;
   logic [TABLE_WIDTH-1:0] order_table_q, order_table_d;
   logic [ADDR_WIDTH-1:0]  order_node_q, order_node_d;
   logic [DATA_WIDTH-1:0]  order_data_q, order_data_d;
   logic [1:0]             rsp_type_q, rsp_type_d;
   logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic                   rsp_ok_q, rsp_ok_d;
   logic                   stale;

`ifdef LT_CLIENT_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WD_W-1:0] wdog_q, wdog_d, stale_cnt_q, stale_cnt_d;
   logic            stale_q, stale_d, rsp_timeout_q, rsp_timeout_d, wd_expired;

   assign wd_expired  = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
   assign stale       = stale_q;
   assign rsp_timeout = rsp_timeout_q;
`else
   assign stale       = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   link_table_cmd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cmd_valid),
      .push_data ({cmd_type, cmd_table, cmd_node, cmd_data}),
      .pop       (fifo_pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign {head_type, head_table, head_node, head_data} = head;

   assign cmd_ready   = !fifo_full;
   assign order_valid = order_valid_q;
   assign order_type  = order_type_q;
   assign order_table = order_table_q;
   assign order_node  = order_node_q;
   assign order_data  = order_data_q;
   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_type    = rsp_type_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_ok      = rsp_ok_q;
   // A stale result is drained even outside WAIT so it cannot be mistaken for a later order's.
   assign dout_busy   = !((state_q == ST_WAIT) || stale);
   assign idle        = fifo_empty && (state_q == ST_IDLE) && !stale;

   always_comb begin
      state_d       = state_q;
      order_valid_d = order_valid_q;
      order_type_d  = order_type_q;
      order_table_d = order_table_q;
      order_node_d  = order_node_q;
      order_data_d  = order_data_q;
      rsp_type_d    = rsp_type_q;
      rsp_data_d    = rsp_data_q;
      rsp_ok_d      = rsp_ok_q;
      fifo_pop      = 1'b0;
`ifdef LT_CLIENT_TIMEOUT_EN
      stale_d       = stale_q;
      stale_cnt_d   = stale_cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !stale) begin
               fifo_pop      = 1'b1;
               order_valid_d = 1'b1;
               order_type_d  = head_type;
               order_table_d = head_table;
               order_node_d  = head_node;
               order_data_d  = head_data;
               state_d       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!order_busy) begin
               order_valid_d = 1'b0;
               state_d       = ST_WAIT;
            end
`ifdef LT_CLIENT_TIMEOUT_EN
            else if (wd_expired) begin
               order_valid_d = 1'b0;
               rsp_type_d    = order_type_q;
               rsp_data_d    = DATA_WIDTH'(LT_FAIL_DATA);
               rsp_ok_d      = 1'b0;
               rsp_timeout_d = 1'b1;
               state_d       = ST_RESP;
            end
`endif
         end
         ST_WAIT: begin
            if (dout_valid) begin
               rsp_type_d = order_type_q;
               rsp_data_d = dout_data;
               rsp_ok_d   = result_ok(order_type_q, dout_data != '0);
`ifdef LT_CLIENT_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
               state_d    = ST_RESP;
            end
`ifdef LT_CLIENT_TIMEOUT_EN
            else if (wd_expired) begin
               rsp_type_d    = order_type_q;
               rsp_data_d    = DATA_WIDTH'(LT_FAIL_DATA);
               rsp_ok_d      = 1'b0;
               rsp_timeout_d = 1'b1;
               stale_d       = 1'b1;
               state_d       = ST_RESP;
            end
`endif
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef LT_CLIENT_TIMEOUT_EN
      // Stale clears on the late result or after a second silent window.
      if (stale_q) begin
         if (dout_valid || stale_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            stale_d     = 1'b0;
            stale_cnt_d = '0;
         end else begin
            stale_cnt_d = stale_cnt_q + 1'b1;
         end
      end
      wdog_d = ((state_d == state_q) && (state_q == ST_ISSUE || state_q == ST_WAIT))
               ? wdog_q + 1'b1 : '0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         order_valid_q <= 1'b0;
         order_type_q  <= '0;
         order_table_q <= '0;
         order_node_q  <= '0;
         order_data_q  <= '0;
         rsp_type_q    <= '0;
         rsp_data_q    <= '0;
         rsp_ok_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         order_valid_q <= order_valid_d;
         order_type_q  <= order_type_d;
         order_table_q <= order_table_d;
         order_node_q  <= order_node_d;
         order_data_q  <= order_data_d;
         rsp_type_q    <= rsp_type_d;
         rsp_data_q    <= rsp_data_d;
         rsp_ok_q      <= rsp_ok_d;
      end
   end

`ifdef LT_CLIENT_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_q        <= '0;
         stale_q       <= 1'b0;
         stale_cnt_q   <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         wdog_q        <= wdog_d;
         stale_q       <= stale_d;
         stale_cnt_q   <= stale_cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end
`endif

endmodule

// File: tb/tb_link_table_client.sv
// Scoreboard bench for link_table_client: a manager model answers orders, a
// monitor checks every host response against a queue of expected results.
module tb_link_table_client;

   localparam int TO = 16;

   typedef struct {
      logic [1:0]  typ;
      logic [7:0]  tbl;
      logic [15:0] node;
      logic [15:0] data;
      logic [15:0] dout;
   } ord_t;

   typedef struct {
      logic [1:0]  typ;
      logic [15:0] data;
      logic        ok;
      logic        tmo;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_type;
   logic [7:0]  cmd_table;
   logic [15:0] cmd_node, cmd_data;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_type;
   logic [15:0] rsp_data;
   logic        rsp_ok, rsp_timeout;
   logic        order_valid, order_busy;
   logic [1:0]  order_type;
   logic [7:0]  order_table;
   logic [15:0] order_node, order_data;
   logic        dout_valid, dout_busy;
   logic [15:0] dout_data;
   logic        idle;

   int   total = 0;
   int   bad = 0;
   ord_t order_q[$];
   rsp_t rsp_q[$];
   int   ready_mode = 1;   // 0 low, 1 high, 2 random
   int   mgr_busy = 1;
   int   mgr_rand = 0;
   int   mgr_mode = 0;     // 0 normal, 1 never accept, 2 accept but answer late
   int   hold_extra = 0;

   always #5 clk = ~clk;

   link_table_client #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_table(cmd_table), .cmd_node(cmd_node), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
      .rsp_data(rsp_data), .rsp_ok(rsp_ok), .rsp_timeout(rsp_timeout),
      .order_valid(order_valid), .order_busy(order_busy), .order_type(order_type),
      .order_table(order_table), .order_node(order_node), .order_data(order_data),
      .dout_valid(dout_valid), .dout_busy(dout_busy), .dout_data(dout_data),
      .idle(idle)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: expected response follows directly from command type and manager result.
   task automatic push(input logic [1:0] t, input logic [7:0] tb, input logic [15:0] n,
                       input logic [15:0] d, input logic [15:0] dout, input bit tmo);
      ord_t o;
      rsp_t r;
      int   w;
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_table = tb;
      cmd_node  = n;
      cmd_data  = d;
      w = 0;
      while (!cmd_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("cmd_accept_wait", (w < 500), 1);
      o.typ = t; o.tbl = tb; o.node = n; o.data = d; o.dout = dout;
      r.typ = t;
      r.tmo = tmo;
      r.data = tmo ? 16'h0 : dout;
      r.ok = tmo ? 1'b0 : ((t == 2'b11) || (dout != 16'h0));
      order_q.push_back(o);
      rsp_q.push_back(r);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((rsp_q.size() != 0 || !idle) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      check("drain_pending", rsp_q.size(), 0);
   endtask

   // Host response acceptance, changed just after each active edge.
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rsp_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
      end
   end

   // Response monitor.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               e = rsp_q.pop_front();
               check("rsp_type", rsp_type, e.typ);
               check("rsp_data", rsp_data, e.data);
               check("rsp_ok", rsp_ok, e.ok);
               check("rsp_timeout", rsp_timeout, e.tmo);
            end
         end
      end
   end

   // Manager model.
   initial begin
      ord_t it;
      int   cnt;
      int   b;
      order_busy = 1'b1;
      dout_valid = 1'b0;
      dout_data  = 16'h0;
      forever begin
         @(negedge clk);
         if (!rst && order_valid) begin
            if (order_q.size() == 0) begin
               check("order_unexpected", 1, 0);
               it.typ = 0; it.tbl = 0; it.node = 0; it.data = 0; it.dout = 0;
            end else begin
               it = order_q.pop_front();
            end
            check("order_type", order_type, it.typ);
            check("order_table", order_table, it.tbl);
            check("order_node", order_node, it.node);
            check("order_data", order_data, it.data);
            if (mgr_mode == 1) begin
               cnt = 0;
               while (order_valid && cnt < 200) begin
                  cnt++;
                  @(negedge clk);
               end
               check("issue_timeout_cycles", cnt, TO);
            end else begin
               b = mgr_rand ? int'($urandom_range(0, 3)) : mgr_busy;
               repeat (b) @(negedge clk);
               check("order_held", order_valid, 1);
               order_busy = 1'b0;
               @(negedge clk);
               order_busy = 1'b1;
               check("order_drop", order_valid, 0);
               if (mgr_mode == 2) repeat (TO + 8) @(negedge clk);
               else repeat (mgr_rand ? int'($urandom_range(0, 4)) : 1) @(negedge clk);
               dout_valid = 1'b1;
               dout_data  = it.dout;
               cnt = 0;
               while (dout_busy && cnt < 300) begin
                  @(negedge clk);
                  cnt++;
               end
               check("dout_taken", (cnt < 300), 1);
               @(negedge clk);
               for (int k = 0; k < hold_extra; k++) begin
                  check("dout_busy_hold", dout_busy, 1);
                  @(negedge clk);
               end
               dout_valid = 1'b0;
            end
         end
      end
   end

   initial begin
      int w;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_type = 2'b00;
      cmd_table = 8'h0;
      cmd_node = 16'h0;
      cmd_data = 16'h0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_dout_busy", dout_busy, 1);
      check("rst_idle", idle, 1);
      check("rst_order_valid", order_valid, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed: write, read back, fatal result.
      push(2'b10, 8'd3, 16'd2, 16'h00AA, 16'h0001, 0);
      drain();
      push(2'b11, 8'd3, 16'd2, 16'h0000, 16'h00AA, 0);
      drain();
      push(2'b00, 8'd1, 16'd7, 16'h1234, 16'h0000, 0);
      drain();

      // FIFO fills while the host withholds rsp_ready.
      ready_mode = 0;
      for (int i = 0; i < 5; i++) push(2'(i), 8'(i), 16'(i + 10), 16'(i * 3), 16'(i + 1), 0);
      repeat (10) @(negedge clk);
      check("full_cmd_ready", cmd_ready, 0);
      check("full_rsp_valid", rsp_valid, 1);
      ready_mode = 1;
      drain();

      // Manager keeps dout_valid high while the response waits.
      hold_extra = 5;
      ready_mode = 0;
      push(2'b01, 8'd9, 16'd4, 16'h0, 16'h0042, 0);
      w = 0;
      while (!rsp_valid && w < 200) begin
         @(negedge clk);
         w++;
      end
      repeat (10) @(negedge clk);
      ready_mode = 1;
      drain();
      hold_extra = 0;

      // Randomised traffic.
      ready_mode = 2;
      mgr_rand = 1;
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  t;
         logic [15:0] dv;
         t  = 2'($urandom_range(0, 3));
         dv = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         push(t, 8'($urandom), 16'($urandom), 16'($urandom), dv, 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();
      mgr_rand = 0;
      ready_mode = 1;

      // Reset in the middle of queued work.
      ready_mode = 0;
      for (int i = 0; i < 3; i++) push(2'b10, 8'd5, 16'(i), 16'(i), 16'h0007, 0);
      repeat (15) @(negedge clk);
      check("mid_rsp_valid", rsp_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_idle", idle, 1);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_cmd_ready", cmd_ready, 1);
      check("mid_rst_dout_busy", dout_busy, 1);
      rsp_q.delete();
      order_q.delete();
      rst = 1'b0;
      ready_mode = 1;
      repeat (5) @(negedge clk);
      check("post_rst_order_valid", order_valid, 0);
      push(2'b11, 8'd2, 16'd8, 16'h0, 16'hBEEF, 0);
      drain();

`ifdef LT_CLIENT_TIMEOUT_EN
      // Watchdog expiry in ISSUE.
      mgr_mode = 1;
      push(2'b11, 8'd4, 16'd1, 16'h0, 16'h1111, 1);
      drain();
      mgr_mode = 0;
      // Watchdog expiry in WAIT; the late result must be discarded.
      mgr_mode = 2;
      push(2'b10, 8'd4, 16'd2, 16'h5, 16'h2222, 1);
      w = 0;
      while (rsp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      mgr_mode = 0;
      push(2'b10, 8'd4, 16'd3, 16'h6, 16'h0055, 0);
      check("stale_blocks_issue", order_valid, 0);
      check("stale_not_idle", idle, 0);
      drain();
`endif

      check("final_order_q", order_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
